// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Two-stage instruction fetch (address issue, IF/ID capture).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [3:0]  ifid_opcode,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid
);

    localparam logic [31:0] c_pc_step = PC_STEP[31:0];

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_req_valid;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic        r_ifid_valid;

    // Under stall the outstanding address is re-issued so the synchronous
    // memory keeps returning data for req_pc.
    always_comb begin
        imem_addr = r_pc;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (redirect) begin
            imem_addr = redirect_pc;
        end else if (stall) begin
            imem_addr = r_req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC + c_pc_step;
            r_req_pc     <= RESET_PC;
            r_req_valid  <= 1'b1;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= 32'h0;
            r_ifid_pc    <= 32'h0;
        end else if (redirect) begin
            r_pc         <= redirect_pc + c_pc_step;
            r_req_pc     <= redirect_pc;
            r_req_valid  <= 1'b1;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= 32'h0;
        end else if (!stall) begin
            r_pc         <= r_pc + c_pc_step;
            r_req_pc     <= r_pc;
            r_req_valid  <= 1'b1;
            r_ifid_valid <= r_req_valid;
            r_ifid_pc    <= r_req_pc;
            // An invalid slot always carries a NOP encoding to decode.
            r_ifid_instr <= r_req_valid ? imem_rdata : 32'h0;
        end
    end

    assign ifid_instr  = r_ifid_instr;
    assign ifid_opcode = r_ifid_instr[31:28];
    assign ifid_pc     = r_ifid_pc;
    assign ifid_valid  = r_ifid_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [3:0]  ifid_opcode;
    logic [31:0] ifid_pc;
    logic        ifid_valid;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ifid_instr  (ifid_instr),
        .ifid_opcode (ifid_opcode),
        .ifid_pc     (ifid_pc),
        .ifid_valid  (ifid_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 28) | a;
    endfunction

    // Synchronous-read instruction memory
    always_ff @(posedge clk) begin
        imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'd1);
        chk({tag, "_pc"}, ifid_pc, pc);
        chk({tag, "_instr"}, ifid_instr, mem_word(pc));
        chk({tag, "_opcode"}, {28'b0, ifid_opcode}, {28'b0, mem_word(pc)}>>28);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'd0);
        chk({tag, "_instr"}, ifid_instr, 32'h0);
        chk({tag, "_opcode"}, {28'b0, ifid_opcode}, 32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        chk("rst_addr", imem_addr, 32'h0);
        step();
        step();
        chk_bubble("rst");
        chk("rst_pc", ifid_pc, 32'h0);

        // Run from reset
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid($sformatf("run%0d", i), i[31:0]);
        end

        // Stall three cycles holding ifid_pc=2
        stall = 1'b1;
        #1;
        chk("stall_addr", imem_addr, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid($sformatf("stall%0d", i), 32'd2);
            chk($sformatf("stall%0d_addr", i), imem_addr, 32'd3);
        end
        stall = 1'b0;
        for (int i = 3; i < 6; i++) begin
            step();
            chk_ifid($sformatf("resume%0d", i), i[31:0]);
        end

        // Redirect to 0x40 while ifid_pc=5
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("redir_addr", imem_addr, 32'h40);
        step();
        chk_bubble("redir_flush");
        redirect = 1'b0;
        step();
        chk_ifid("redir_t0", 32'h40);
        step();
        chk_ifid("redir_t1", 32'h41);

        // Redirect with simultaneous stall
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h80;
        #1;
        chk("rs_addr", imem_addr, 32'h80);
        step();
        chk_bubble("rs_flush");
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        chk_ifid("rs_t0", 32'h80);
        step();
        chk_ifid("rs_t1", 32'h81);

        // Address wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        chk_bubble("wrap_flush");
        redirect = 1'b0;
        step();
        chk_ifid("wrap_t0", 32'hFFFF_FFFE);
        step();
        chk_ifid("wrap_t1", 32'hFFFF_FFFF);
        step();
        chk_ifid("wrap_t2", 32'h0000_0000);

        // Reach pc=9, stall, then reset mid-stall
        redirect    = 1'b1;
        redirect_pc = 32'd7;
        step();
        redirect = 1'b0;
        step();
        chk_ifid("pre_rst", 32'd7);
        stall = 1'b1;
        step();
        chk_ifid("pre_rst_stall", 32'd7);
        rst = 1'b1;
        #1;
        chk("mid_rst_addr", imem_addr, 32'h0);
        step();
        chk_bubble("mid_rst");
        chk("mid_rst_pc", ifid_pc, 32'h0);
        rst   = 1'b0;
        stall = 1'b0;
        step();
        chk_ifid("post_rst0", 32'd0);
        step();
        chk_ifid("post_rst1", 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 1: PC increment per fetch, in words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold request from downstream; freezes the fetch pipe.
REQ-006 redirect  input  1  taken branch or jump; restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  target address, valid when redirect=1.
REQ-008 imem_addr  output  32  instruction memory address, combinational.
REQ-009 imem_rdata  input  32  synchronous-read data for the address presented on the previous cycle.
REQ-010 ifid_instr  output  32  registered instruction handed to decode.
REQ-011 ifid_opcode  output  4  equals ifid_instr[31:28]; feeds the control unit opcode input.
REQ-012 ifid_pc  output  32  registered address of ifid_instr.
REQ-013 ifid_valid  output  1  ifid_instr is a real fetched instruction.

Function
REQ-014 The internal state SHALL be: pc (next address to request), req_pc/req_valid (request outstanding at the memory), and the IF/ID register.
REQ-015 The block SHALL be a 2-stage pipe: address issued in cycle n, data captured into IF/ID at the end of cycle n+1.
REQ-016 imem_addr SHALL be: redirect_pc if redirect=1; else req_pc if stall=1; else pc.
REQ-017 Normal cycle (redirect=0, stall=0):
- req_pc<=pc, req_valid<=1, pc<=pc+PC_STEP
- ifid_instr<=imem_rdata, ifid_pc<=req_pc, ifid_valid<=req_valid
REQ-018 Stall cycle (redirect=0, stall=1): pc, req_pc, req_valid and the IF/ID register SHALL hold. Re-issuing req_pc makes imem_rdata on the next cycle still correspond to req_pc.
REQ-019 Redirect cycle (redirect=1, regardless of stall):
- req_pc<=redirect_pc, req_valid<=1, pc<=redirect_pc+PC_STEP
- ifid_valid<=0, ifid_instr<=0 (flush)
REQ-020 Redirect SHALL have priority over stall; stall SHALL have priority over normal advance.
REQ-021 Whenever ifid_valid is loaded with 0, ifid_instr SHALL be loaded with 32'h0, so decode sees opcode 4'b0000 (NOP).
REQ-022 The next cycle's first valid instruction after a redirect SHALL be mem[redirect_pc], exactly one bubble later.
REQ-023 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFF + 1 wraps to 0 with no error indication.
REQ-024 Instructions SHALL never be dropped or duplicated across any sequence of stall and normal cycles without redirect.

Reset
REQ-025 While rst=1 at a rising edge, the following SHALL be loaded, overriding stall and redirect:
- pc<=RESET_PC+PC_STEP, req_pc<=RESET_PC, req_valid<=1
- ifid_valid<=0, ifid_instr<=0, ifid_pc<=0
REQ-026 While rst=1, imem_addr SHALL equal RESET_PC.
REQ-027 The first ifid_valid=1 SHALL occur one cycle after rst deasserts (first edge with rst=0), with ifid_pc=RESET_PC.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight requests.

Verification
REQ-029 Reset then run: memory mem[i]=i<<28|i, RESET_PC=0 -> ifid_pc 0,1,2,3 on consecutive cycles; ifid_opcode 0,1,2,3; ifid_valid=1 from the first post-reset edge.
REQ-030 Stall 3 cycles while ifid_pc=2 -> ifid_pc holds 2 for 3 cycles, then 3,4; no skipped or repeated PC; imem_addr=3 during the stall.
REQ-031 Redirect to 32'h40 while ifid_pc=5 -> next cycle ifid_valid=0 and ifid_instr=0; following cycle ifid_pc=32'h40, then 32'h41.
REQ-032 Redirect and stall asserted together -> redirect behaviour identical to REQ-031.
REQ-033 Wrap: redirect to 32'hFFFF_FFFE -> ifid_pc FFFF_FFFE, FFFF_FFFF, 0000_0000.
REQ-034 Reset asserted during a stall, with pc=9 -> after reset, ifid_pc restarts at RESET_PC with no stale instruction marked valid.
